// File: rtl/pixel_plotter.sv
// Pixel plotter: turns (x, y, color) into linear frame-buffer writes through a small FIFO.
// Latency: a write appears one cycle after a coordinate is accepted into an empty FIFO.
// Backpressure: pixel_ready = not full; the head entry is held stable while wr_ready is low.
// Optional clipping of off-screen coordinates is enabled by defining PIXEL_PLOTTER_CLIP_EN.
module pixel_plotter #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 400,
   parameter int DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pixel_valid,
   input  logic [9:0]  horizontal,
   input  logic [8:0]  vertical,
   input  logic [3:0]  color,
   output logic        pixel_ready,
   output logic        wr_valid,
   output logic [18:0] wr_addr,
   output logic [3:0]  wr_data,
   input  logic        wr_ready,
   output logic        busy,
   output logic [15:0] dropped
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Reject configurations the pointer arithmetic and address width cannot represent.
   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH * HEIGHT > 524288) begin : g_bad_cfg
      $error("pixel_plotter: unsupported parameter combination");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [18:0]   addr_mem_q [DEPTH];
   logic [18:0]   addr_mem_d [DEPTH];
   logic [3:0]    data_mem_q [DEPTH];
   logic [3:0]    data_mem_d [DEPTH];
   logic [15:0]   dropped_q, dropped_d;

   logic        accept;
   logic        in_range;
   logic        push;
   logic        pop;
   logic [18:0] pix_addr;

   // Ready comes only from registered occupancy; reset holds it low.
   assign pixel_ready = ~reset & (count_q != FULL_CNT);
   assign wr_valid    = (count_q != '0);
   assign busy        = wr_valid;
   assign wr_addr     = addr_mem_q[rd_ptr_q];
   assign wr_data     = data_mem_q[rd_ptr_q];
   assign dropped     = dropped_q;

   assign accept   = pixel_valid & pixel_ready;
   assign pop      = wr_valid & wr_ready;
   assign pix_addr = 19'(vertical) * 19'(WIDTH) + 19'(horizontal);

`ifdef PIXEL_PLOTTER_CLIP_EN
   assign in_range = ({1'b0, horizontal} < 11'(WIDTH)) && ({1'b0, vertical} < 10'(HEIGHT));
`else
   assign in_range = 1'b1;
`endif

   // Off-screen coordinates still complete the handshake but never reach the FIFO.
   assign push = accept & in_range;

   // Next-state for pointers, occupancy, storage and the clip counter.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      addr_mem_d = addr_mem_q;
      data_mem_d = data_mem_q;
      dropped_d  = dropped_q;

      if (push) begin
         addr_mem_d[wr_ptr_q] = pix_addr;
         data_mem_d[wr_ptr_q] = color;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

`ifdef PIXEL_PLOTTER_CLIP_EN
      if (accept && !in_range && dropped_q != 16'hFFFF) begin
         dropped_d = dropped_q + 1'b1;
      end
`else
      dropped_d = '0;
`endif
   end

   // State registers; reset discards every queued entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         dropped_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem_q[i] <= '0;
            data_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         dropped_q  <= dropped_d;
         addr_mem_q <= addr_mem_d;
         data_mem_q <= data_mem_d;
      end
   end

endmodule

// File: tb/tb_pixel_plotter.sv
// Bench for pixel_plotter: directed steps with a write scoreboard.
// Expected writes are queued when a handshake is seen and matched when the plotter writes.
// Build with or without PIXEL_PLOTTER_CLIP_EN; the reference model follows the same macro.
module tb_pixel_plotter;

   logic        clk = 1'b0;
   logic        reset;
   logic        pixel_valid;
   logic [9:0]  horizontal;
   logic [8:0]  vertical;
   logic [3:0]  color;
   logic        pixel_ready;
   logic        wr_valid;
   logic [18:0] wr_addr;
   logic [3:0]  wr_data;
   logic        wr_ready;
   logic        busy;
   logic [15:0] dropped;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   int n_wr     = 0;

   logic [22:0] sb [$];

   logic        prev_stall = 1'b0;
   logic [18:0] prev_addr  = '0;
   logic [3:0]  prev_data  = '0;

   pixel_plotter #(.WIDTH(640), .HEIGHT(400), .DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .pixel_valid (pixel_valid),
      .horizontal  (horizontal),
      .vertical    (vertical),
      .color       (color),
      .pixel_ready (pixel_ready),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .busy        (busy),
      .dropped     (dropped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Handshake tracker: queue the expected write for each accepted on-screen pixel.
   always @(negedge clk) begin
      if (!reset && pixel_valid && pixel_ready) begin
         bit onscreen;
         n_acc++;
`ifdef PIXEL_PLOTTER_CLIP_EN
         onscreen = (horizontal < 640) && (vertical < 400);
`else
         onscreen = 1'b1;
`endif
         if (onscreen)
            sb.push_back({19'(int'(vertical) * 640 + int'(horizontal)), color});
      end
   end

   // Write monitor: stability under backpressure and in-order contents.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         check("busy_eq_wr_valid", busy, wr_valid);
         if (prev_stall) begin
            check("stall_valid", wr_valid, 1);
            check("stall_addr", wr_addr, prev_addr);
            check("stall_data", wr_data, prev_data);
         end
         if (wr_valid && wr_ready) begin
            check("write_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               logic [22:0] e;
               e = sb.pop_front();
               check("wr_addr", wr_addr, e[22:4]);
               check("wr_data", wr_data, e[3:0]);
            end
            n_wr++;
         end
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   // Offer one pixel (called just after a rising edge) and hold it until accepted.
   task automatic send(input int x, input int y, input int c);
      bit got;
      got = 1'b0;
      pixel_valid = 1'b1;
      horizontal  = 10'(x);
      vertical    = 9'(y);
      color       = 4'(c);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pixel_ready) got = 1'b1;
         @(posedge clk);
         #1;
         if (got) break;
      end
      check("send_accept", got, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         if (sb.size() == 0) break;
         sample();
      end
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin
      int a0;
      int w0;
      reset       = 1'b1;
      pixel_valid = 1'b0;
      horizontal  = '0;
      vertical    = '0;
      color       = '0;
      wr_ready    = 1'b0;
      #3;
      check("rst_wr_valid", wr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pixel_ready", pixel_ready, 0);
      check("rst_dropped", dropped, 0);
      step();
      step();
      reset = 1'b0;
      sample();
      check("post_rst_ready", pixel_ready, 1);

      // Single pixel with an always-ready frame buffer.
      step();
      wr_ready = 1'b1;
      send(3, 2, 5);
      pixel_valid = 1'b0;
      sample();
      check("first_wr_valid", wr_valid, 1);
      check("first_wr_addr", wr_addr, 1283);
      check("first_wr_data", wr_data, 5);
      sample();
      check("first_done", wr_valid, 0);

      // Fill to full with the frame buffer stalled, then release.
      step();
      wr_ready = 1'b0;
      a0 = n_acc;
      for (int i = 1; i <= 4; i++) send(10 * i, i, i);
      pixel_valid = 1'b1;
      horizontal  = 10'd50;
      vertical    = 9'd5;
      color       = 4'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_ready_low", pixel_ready, 0);
         check("full_wr_valid", wr_valid, 1);
         @(posedge clk);
         #1;
      end
      check("full_accept_count", n_acc - a0, 4);
      wr_ready = 1'b1;
      send(50, 5, 5);
      send(60, 6, 6);
      pixel_valid = 1'b0;
      drain();
      check("stall_accept_count", n_acc - a0, 6);
      sample();
      check("stall_idle", wr_valid, 0);

      // Streaming: one write per cycle, no bubbles.
      step();
      w0 = n_wr;
      for (int i = 0; i < 8; i++) begin
         pixel_valid = 1'b1;
         horizontal  = 10'(100 + i);
         vertical    = 9'd7;
         color       = 4'(i);
         @(negedge clk);
         check("stream_ready", pixel_ready, 1);
         if (i > 0) check("stream_no_bubble", wr_valid, 1);
         @(posedge clk);
         #1;
      end
      pixel_valid = 1'b0;
      sample();
      sample();
      check("stream_writes", n_wr - w0, 8);
      check("stream_idle", wr_valid, 0);

      // Off-screen coordinates.
      step();
      send(640, 0, 1);
      send(0, 400, 2);
      pixel_valid = 1'b0;
      sample();
      sample();
`ifdef PIXEL_PLOTTER_CLIP_EN
      check("clip_dropped", dropped, 2);
      check("clip_no_write", wr_valid, 0);
`else
      drain();
      check("noclip_dropped", dropped, 0);
`endif

      // Reset mid-stream with queued entries.
      step();
      wr_ready = 1'b0;
      send(1, 1, 1);
      send(2, 2, 2);
      send(3, 3, 3);
      pixel_valid = 1'b0;
      sample();
      check("pre_rst_wr_valid", wr_valid, 1);
      check("pre_rst_busy", busy, 1);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_wr_valid", wr_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", pixel_ready, 0);
      check("mid_rst_dropped", dropped, 0);
      sb.delete();
      @(negedge clk);
      #2;
      reset = 1'b0;
      step();
      wr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("post_rst_no_write", wr_valid, 0);
      end
      check("post_rst_ready2", pixel_ready, 1);

`ifdef PIXEL_PLOTTER_CLIP_EN
      // Saturation of the clip counter.
      step();
      pixel_valid = 1'b1;
      horizontal  = 10'd700;
      vertical    = 9'd0;
      color       = 4'd0;
      repeat (65535) @(posedge clk);
      #1;
      check("sat_reach", dropped, 65535);
      repeat (2) @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      check("sat_hold", dropped, 65535);
      check("sat_no_write", wr_valid, 0);
`else
      check("end_dropped", dropped, 0);
`endif

      sample();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pixel_plotter.md
PIXEL_PLOTTER -- requirements
Module: pixel_plotter

Interface
REQ-001 Parameter WIDTH, default 640, display width in pixels; horizontal coordinates at or above WIDTH are off-screen.
REQ-002 Parameter HEIGHT, default 400, display height in pixels; vertical coordinates at or above HEIGHT are off-screen.
REQ-003 Parameter DEPTH, default 4, FIFO entries, power of two, 2..16.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pixel_valid  in  1  coordinate offered.
REQ-007 horizontal  in  10  pixel x.
REQ-008 vertical  in  9  pixel y.
REQ-009 color  in  4  palette index for the pixel.
REQ-010 pixel_ready  out  1  plotter accepts a coordinate this cycle.
REQ-011 wr_valid  out  1  frame-buffer write request pending.
REQ-012 wr_addr  out  19  linear frame-buffer address.
REQ-013 wr_data  out  4  palette index to write.
REQ-014 wr_ready  in  1  frame buffer accepts the write this cycle.
REQ-015 busy  out  1  FIFO holds at least one entry.
REQ-016 dropped  out  16  count of clipped pixels.

Function
REQ-017 A coordinate SHALL be accepted on a rising edge where pixel_valid and pixel_ready are both high.
REQ-018 pixel_ready SHALL equal NOT full, derived from the registered occupancy count; it SHALL be independent of pixel_valid and of the same-cycle wr_ready.
REQ-019 The address SHALL be computed as vertical*WIDTH + horizontal, zero-extended to 19 bits, and stored with color in the same FIFO entry.
REQ-020 Entries SHALL leave in first-in, first-out order; wr_valid, wr_addr and wr_data SHALL present the head entry.
REQ-021 wr_valid SHALL be high exactly when occupancy is nonzero; the first write SHALL appear one cycle after acceptance into an empty FIFO.
REQ-022 An entry SHALL pop on a rising edge where wr_valid and wr_ready are both high.
REQ-023 wr_addr and wr_data SHALL stay stable while wr_valid is high and wr_ready is low.
REQ-024 A push and a pop on the same edge SHALL leave occupancy unchanged; this case is legal from any non-full, non-empty state.
REQ-025 When the FIFO is full, pixel_ready SHALL be low and no entry SHALL be overwritten; a pop on that edge SHALL raise pixel_ready in the next cycle.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-027 busy SHALL equal wr_valid.
REQ-028 dropped SHALL saturate at 65535 and SHALL never wrap.

Reset
REQ-029 Asserting reset SHALL immediately clear occupancy and pointers, and force wr_valid=0, busy=0, dropped=0 and pixel_ready=0.
REQ-030 pixel_ready SHALL rise in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-stream SHALL discard all queued entries, with no partial write presented afterwards.

Configuration
REQ-032 With PIXEL_PLOTTER_CLIP_EN defined, an accepted coordinate where horizontal >= WIDTH or vertical >= HEIGHT SHALL be consumed (handshake completes), not enqueued, and SHALL increment dropped.
REQ-033 Without PIXEL_PLOTTER_CLIP_EN, every accepted coordinate SHALL be enqueued unchecked, and dropped SHALL be held at 0.

Verification
REQ-034 After reset, accept (x=3, y=2, color=5) with wr_ready=1 -> one cycle later wr_valid=1, wr_addr=1283, wr_data=5; next cycle wr_valid=0.
REQ-035 With wr_ready=0, offer 6 pixels back-to-back with DEPTH=4 -> exactly 4 accepted and pixel_ready=0; then set wr_ready=1 -> writes drain in order, and pixels 5 and 6 are accepted afterwards.
REQ-036 Continuous push with wr_ready=1 -> occupancy holds at 1 and one write completes per cycle with no bubbles.
REQ-037 With clip enabled, offer (x=640, y=0) then (x=0, y=400) -> both handshakes complete, no wr_valid, dropped=2; without clip, the same stimulus -> wr_addr=640, then wr_addr=256000.
REQ-038 Fill 3 entries, then assert reset for one cycle mid-clock -> wr_valid and busy drop immediately, with no stale writes after release.
REQ-039 Force 65537 clipped pixels -> dropped reads 65535.
